// File: rtl/dcache_sram_nway.sv
// rtl/dcache_sram_nway.sv - N-way set-associative cache tag/data store with true LRU and flush/writeback FSM
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   addr_i, tag_i, data_i             set index, {v,d,tag} entry, line for lookup/write
//   enable_i, write_i                 access request and write qualifier
//   tag_o, data_o, hit_o, way_o       lookup result (hit way, or victim on a miss)
//   flush_i, flush_busy_o, flush_done_o  flush control and status
//   wb_valid_o, wb_ready_i, wb_addr_o, wb_tag_o, wb_data_o  dirty-line writeback offer
module dcache_sram_nway #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 23,
    parameter int LINE_W   = 256,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int TE_W    = TAG_W + 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TE_W-1:0]   tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic [TE_W-1:0]   tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    input  logic              flush_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [IDX_W-1:0]  wb_addr_o,
    output logic [TE_W-1:0]   wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o
);

    localparam int VB = TE_W - 1;
    localparam int DB = TE_W - 2;
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  scan_set_q, scan_set_d;
    logic [WAY_W-1:0]  scan_way_q, scan_way_d;
    logic              done_q, done_d;

    logic [TE_W-1:0]   tag_q  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] data_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  age_q  [NUM_SETS][NUM_WAYS];

    logic              busy, acc_en, any_hit, have_inv;
    logic              do_write, do_touch, wb_hs, scan_last, scan_dirty, adv;
    logic [WAY_W-1:0]  hit_way, inv_way, oldest_way, victim_way, sel_way;
    logic [WAY_W-1:0]  max_age;
    logic [WAY_W-1:0]  age_new [NUM_WAYS];

    assign busy   = (state_q != IDLE);
    assign acc_en = enable_i & ~busy;

    // Lookup: lowest-index hit, lowest-index invalid way, and oldest way of the addressed set.
    always_comb begin
        any_hit    = 1'b0;
        hit_way    = '0;
        have_inv   = 1'b0;
        inv_way    = '0;
        oldest_way = '0;
        max_age    = age_q[addr_i][0];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (tag_q[addr_i][w][VB] && (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
                any_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!tag_q[addr_i][w][VB]) begin
                have_inv = 1'b1;
                inv_way  = WAY_W'(w);
            end
        end
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (age_q[addr_i][w] > max_age) begin
                max_age    = age_q[addr_i][w];
                oldest_way = WAY_W'(w);
            end
        end
    end

    assign victim_way = have_inv ? inv_way : oldest_way;
    assign sel_way    = any_hit ? hit_way : victim_way;
    assign do_write   = acc_en & write_i;
    assign do_touch   = do_write | (acc_en & any_hit);

    // Touch of sel_way: it becomes youngest, ways younger than it age by one.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_new[w] = age_q[addr_i][w];
            if (WAY_W'(w) == sel_way)
                age_new[w] = '0;
            else if (age_q[addr_i][w] < age_q[addr_i][sel_way])
                age_new[w] = age_q[addr_i][w] + WAY_W'(1);
        end
    end

    // Outputs reflect pre-edge contents so the victim can be captured while the refill is written.
    assign hit_o  = acc_en & any_hit;
    assign way_o  = acc_en ? sel_way : '0;
    assign tag_o  = acc_en ? tag_q[addr_i][sel_way] : '0;
    assign data_o = acc_en ? data_q[addr_i][sel_way] : '0;

    assign scan_dirty = tag_q[scan_set_q][scan_way_q][VB] & tag_q[scan_set_q][scan_way_q][DB];
    assign scan_last  = (scan_set_q == LAST_SET) && (scan_way_q == LAST_WAY);
    assign wb_hs      = (state_q == EMIT) & wb_ready_i;

    always_comb begin
        state_d    = state_q;
        scan_set_d = scan_set_q;
        scan_way_d = scan_way_q;
        done_d     = 1'b0;
        adv        = 1'b0;
        case (state_q)
            IDLE: if (flush_i) begin
                state_d    = SCAN;
                scan_set_d = '0;
                scan_way_d = '0;
            end
            SCAN: if (scan_dirty) state_d = EMIT;
                  else            adv     = 1'b1;
            EMIT: if (wb_ready_i) adv = 1'b1;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (scan_last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = SCAN;
                if (scan_way_q == LAST_WAY) begin
                    scan_way_d = '0;
                    scan_set_d = scan_set_q + IDX_W'(1);
                end else begin
                    scan_way_d = scan_way_q + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            scan_set_q <= '0;
            scan_way_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_set_q <= scan_set_d;
            scan_way_q <= scan_way_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= WAY_W'(w);
                end
            end
        end else begin
            if (do_write) begin
                tag_q[addr_i][sel_way]  <= tag_i;
                data_q[addr_i][sel_way] <= data_i;
            end
            if (do_touch) begin
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[addr_i][w] <= age_new[w];
            end
            // Writeback accepted: line is now clean but stays resident.
            if (wb_hs)
                tag_q[scan_set_q][scan_way_q][DB] <= 1'b0;
        end
    end

    assign flush_busy_o = busy;
    assign flush_done_o = done_q;
    assign wb_valid_o   = (state_q == EMIT);
    assign wb_addr_o    = wb_valid_o ? scan_set_q : '0;
    assign wb_tag_o     = wb_valid_o ? tag_q[scan_set_q][scan_way_q] : '0;
    assign wb_data_o    = wb_valid_o ? data_q[scan_set_q][scan_way_q] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb/tb_dcache_sram_nway.sv - self-checking bench for dcache_sram_nway
module tb_dcache_sram_nway;
    localparam int IDX_W  = 4;
    localparam int WAY_W  = 2;
    localparam int TE_W   = 25;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [IDX_W-1:0]  addr_i = '0;
    logic [TE_W-1:0]   tag_i = '0;
    logic [LINE_W-1:0] data_i = '0;
    logic              enable_i = 1'b0, write_i = 1'b0, flush_i = 1'b0, wb_ready_i = 1'b0;
    logic [TE_W-1:0]   tag_o, wb_tag_o;
    logic [LINE_W-1:0] data_o, wb_data_o;
    logic              hit_o, flush_busy_o, flush_done_o, wb_valid_o;
    logic [WAY_W-1:0]  way_o;
    logic [IDX_W-1:0]  wb_addr_o;

    dcache_sram_nway dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
        .enable_i(enable_i), .write_i(write_i), .tag_o(tag_o), .data_o(data_o),
        .hit_o(hit_o), .way_o(way_o), .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .flush_done_o(flush_done_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_addr_o(wb_addr_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [TE_W-1:0] te(input logic v, input logic d, input logic [22:0] t);
        return {v, d, t};
    endfunction

    function automatic logic [LINE_W-1:0] dat(input logic [31:0] n);
        return {8{32'hD00D_0000 ^ n}};
    endfunction

    typedef struct {
        string             name;
        logic              en, wr;
        logic [IDX_W-1:0]  addr;
        logic [TE_W-1:0]   tag;
        logic [LINE_W-1:0] data;
        logic              ehit;
        logic [WAY_W-1:0]  eway;
        logic [TE_W-1:0]   etag;
        logic [LINE_W-1:0] edata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic en, input logic wr, input logic [IDX_W-1:0] a,
                       input logic [TE_W-1:0] t, input logic [LINE_W-1:0] d, input logic eh,
                       input logic [WAY_W-1:0] ew, input logic [TE_W-1:0] et, input logic [LINE_W-1:0] ed);
        vec_t v;
        v.name = nm; v.en = en; v.wr = wr; v.addr = a; v.tag = t; v.data = d;
        v.ehit = eh; v.eway = ew; v.etag = et; v.edata = ed;
        vq.push_back(v);
    endtask

    // Drive one access away from the rising edge; outputs are valid 2ns after the falling edge.
    task automatic drive(input logic en, input logic wr, input logic [IDX_W-1:0] a,
                         input logic [TE_W-1:0] t, input logic [LINE_W-1:0] d);
        @(negedge clk);
        enable_i = en; write_i = wr; addr_i = a; tag_i = t; data_i = d;
        #2;
    endtask

    task automatic idle();
        @(negedge clk);
        enable_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic check_access(input string nm, input logic [IDX_W-1:0] a, input logic [22:0] t,
                                input logic eh, input logic [WAY_W-1:0] ew,
                                input logic [TE_W-1:0] et, input logic [LINE_W-1:0] ed);
        drive(1'b1, 1'b0, a, te(1'b1, 1'b0, t), '0);
        chk({nm, ".hit"}, LINE_W'(hit_o), LINE_W'(eh));
        chk({nm, ".way"}, LINE_W'(way_o), LINE_W'(ew));
        chk({nm, ".tag"}, LINE_W'(tag_o), LINE_W'(et));
        chk({nm, ".data"}, data_o, ed);
        idle();
    endtask

    logic [IDX_W-1:0]  exp_addr [2];
    logic [TE_W-1:0]   exp_tag  [2];
    logic [LINE_W-1:0] exp_data [2];

    initial begin
        int hs, dones, stall;
        logic found;

        // Reset: outputs zero even with an access presented.
        enable_i = 1'b1; addr_i = 4'd3; tag_i = te(1'b1, 1'b0, 23'h10);
        @(negedge clk); #2;
        chk("rst.hit", LINE_W'(hit_o), '0);
        chk("rst.way", LINE_W'(way_o), '0);
        chk("rst.tag", LINE_W'(tag_o), '0);
        chk("rst.data", data_o, '0);
        chk("rst.busy", LINE_W'(flush_busy_o), '0);
        chk("rst.wbv", LINE_W'(wb_valid_o), '0);
        chk("rst.done", LINE_W'(flush_done_o), '0);
        @(negedge clk); rst_i = 1'b0; enable_i = 1'b0;

        // Cold fill, LRU eviction, write hit, read miss without state change.
        add("fill0", 1, 1, 3, te(1,0,23'h10), dat(32'h10), 0, 0, '0, '0);
        add("fill1", 1, 1, 3, te(1,0,23'h11), dat(32'h11), 0, 1, '0, '0);
        add("fill2", 1, 1, 3, te(1,0,23'h12), dat(32'h12), 0, 2, '0, '0);
        add("fill3", 1, 1, 3, te(1,0,23'h13), dat(32'h13), 0, 3, '0, '0);
        add("rd10",  1, 0, 3, te(1,0,23'h10), '0, 1, 0, te(1,0,23'h10), dat(32'h10));
        add("evict", 1, 1, 3, te(1,0,23'h20), dat(32'h20), 0, 1, te(1,0,23'h11), dat(32'h11));
        add("wrhit", 1, 1, 3, te(1,0,23'h12), dat(32'h112), 1, 2, te(1,0,23'h12), dat(32'h12));
        add("rd12",  1, 0, 3, te(1,0,23'h12), '0, 1, 2, te(1,0,23'h12), dat(32'h112));
        add("rd10b", 1, 0, 3, te(1,0,23'h10), '0, 1, 0, te(1,0,23'h10), dat(32'h10));
        add("rd13",  1, 0, 3, te(1,0,23'h13), '0, 1, 3, te(1,0,23'h13), dat(32'h13));
        add("rd20",  1, 0, 3, te(1,0,23'h20), '0, 1, 1, te(1,0,23'h20), dat(32'h20));
        add("rdmiss",1, 0, 3, te(1,0,23'h55), '0, 0, 2, te(1,0,23'h12), dat(32'h112));
        add("rdmis2",1, 0, 3, te(1,0,23'h55), '0, 0, 2, te(1,0,23'h12), dat(32'h112));
        add("noen",  0, 0, 3, te(1,0,23'h10), '0, 0, 0, '0, '0);
        add("set5",  1, 0, 5, te(1,0,23'h10), '0, 0, 0, '0, '0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].wr, vq[i].addr, vq[i].tag, vq[i].data);
            chk({vq[i].name, ".hit"}, LINE_W'(hit_o), LINE_W'(vq[i].ehit));
            chk({vq[i].name, ".way"}, LINE_W'(way_o), LINE_W'(vq[i].eway));
            chk({vq[i].name, ".tag"}, LINE_W'(tag_o), LINE_W'(vq[i].etag));
            chk({vq[i].name, ".data"}, data_o, vq[i].edata);
        end
        idle();

        // Dirty lines at (2,1) and (7,3).
        drive(1, 1, 2, te(1,0,23'h30), dat(32'h30));
        drive(1, 1, 2, te(1,1,23'h31), dat(32'h31));
        drive(1, 1, 7, te(1,0,23'h40), dat(32'h40));
        drive(1, 1, 7, te(1,0,23'h41), dat(32'h41));
        drive(1, 1, 7, te(1,0,23'h42), dat(32'h42));
        drive(1, 1, 7, te(1,1,23'h43), dat(32'h43));
        idle();
        exp_addr[0] = 4'd2; exp_tag[0] = te(1,1,23'h31); exp_data[0] = dat(32'h31);
        exp_addr[1] = 4'd7; exp_tag[1] = te(1,1,23'h43); exp_data[1] = dat(32'h43);

        // Flush with 3-cycle writeback stalls.
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        hs = 0; dones = 0; stall = 0;
        for (int c = 0; c < 200; c++) begin
            #2;
            if (flush_done_o) dones++;
            if (wb_valid_o) begin
                if (hs < 2) begin
                    chk($sformatf("wb%0d.addr", hs), LINE_W'(wb_addr_o), LINE_W'(exp_addr[hs]));
                    chk($sformatf("wb%0d.tag", hs), LINE_W'(wb_tag_o), LINE_W'(exp_tag[hs]));
                    chk($sformatf("wb%0d.data", hs), wb_data_o, exp_data[hs]);
                end else begin
                    chk("wb.extra", LINE_W'(wb_valid_o), '0);
                end
                if (stall < 3) stall++;
                else begin wb_ready_i = 1'b1; hs++; stall = 0; end
            end
            @(negedge clk); wb_ready_i = 1'b0;
        end
        chk("flush.handshakes", LINE_W'(hs), LINE_W'(2));
        chk("flush.done_pulses", LINE_W'(dones), LINE_W'(1));
        chk("flush.busy_end", LINE_W'(flush_busy_o), '0);
        check_access("post21", 2, 23'h31, 1, 1, te(1,0,23'h31), dat(32'h31));
        check_access("post73", 7, 23'h43, 1, 3, te(1,0,23'h43), dat(32'h43));

        // Accesses during a flush are ignored.
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 100; c++) begin
            enable_i = 1'b1; write_i = 1'b1; addr_i = 4'd3;
            tag_i = te(1,1,23'h13); data_i = dat(32'hDEAD);
            #2;
            if (flush_done_o) dones++;
            if (flush_busy_o) chk("busy.hit", LINE_W'(hit_o), '0);
            else begin enable_i = 1'b0; write_i = 1'b0; end
            if (wb_valid_o) chk("busy.wbv", LINE_W'(wb_valid_o), '0);
            @(negedge clk);
        end
        idle();
        chk("busy.done_pulses", LINE_W'(dones), LINE_W'(1));
        check_access("busy.keep", 3, 23'h13, 1, 3, te(1,0,23'h13), dat(32'h13));

        // Reset while a writeback is offered.
        drive(1, 1, 4, te(1,1,23'h50), dat(32'h50));
        idle();
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 150 && !found; c++) begin
            #2;
            if (wb_valid_o) found = 1'b1;
            else @(negedge clk);
        end
        chk("rstemit.reached", LINE_W'(found), LINE_W'(1));
        rst_i = 1'b1;
        #1;
        chk("rstemit.wbv", LINE_W'(wb_valid_o), '0);
        chk("rstemit.busy", LINE_W'(flush_busy_o), '0);
        chk("rstemit.wbtag", LINE_W'(wb_tag_o), '0);
        chk("rstemit.wbdata", wb_data_o, '0);
        @(negedge clk); rst_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 100; c++) begin
            #2;
            if (flush_done_o) dones++;
            @(negedge clk);
        end
        chk("rstemit.no_done", LINE_W'(dones), '0);
        check_access("rstemit.set4", 4, 23'h50, 0, 0, '0, '0);
        check_access("rstemit.set3", 3, 23'h13, 0, 0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
